// File: rtl/dc_mem_bridge.sv
// Data-cache line bridge: splits 128-bit writeback/refill requests into 32-bit
// memory beats and gathers refill beats back into a line.
module dc_mem_bridge #(
  parameter int unsigned TOUT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dcw_start_rq,
  input  logic [31:0]  dcw_in_addr,
  input  logic [15:0]  dcw_in_mask,
  input  logic [127:0] dcw_in_data,
  output logic         dcw_finish_wresp,
  input  logic         dcr_start_rq,
  input  logic [31:0]  dcr_rin_addr,
  output logic         rqfull_1,
  output logic [127:0] rdat_m_data,
  output logic         rdat_m_valid,
  output logic         finish_mrd,
  output logic         mem_cmd_valid,
  input  logic         mem_cmd_ready,
  output logic         mem_cmd_we,
  output logic [29:0]  mem_cmd_adr,
  output logic [31:0]  mem_cmd_wdata,
  output logic [3:0]   mem_cmd_be,
  input  logic         mem_rvalid,
  input  logic [31:0]  mem_rdata,
  output logic         bridge_err
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_DONE,
    RD_ISSUE,
    RD_WAIT,
    RD_DONE
  } state_t;

  localparam logic [TOUT_W-1:0] TOUT_LAST = {{(TOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TOUT_W-1:0] TOUT_ONE  = {{(TOUT_W-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic          rd_pend_q, rd_pend_d;
  logic [27:0]   wa_q, wa_d;
  logic [27:0]   ra_q, ra_d;
  logic [15:0]   wm_q, wm_d;
  logic [127:0]  wd_q, wd_d;
  logic [1:0]    cidx_q, cidx_d;
  logic [1:0]    rcnt_q, rcnt_d;
  logic [TOUT_W-1:0] tout_q, tout_d;
  logic [127:0]  line_q, line_d;
  logic [127:0]  rdat_q, rdat_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          cmd_we_q, cmd_we_d;
  logic [29:0]   cmd_adr_q, cmd_adr_d;
  logic [31:0]   cmd_wdata_q, cmd_wdata_d;
  logic [3:0]    cmd_be_q, cmd_be_d;
  logic          wfin_q, wfin_d;
  logic          rdone_q, rdone_d;
  logic          rqfull_q, rqfull_d;
  logic          err_q, err_d;

  logic          start_rd;
  logic [27:0]   rd_base;
  logic [2:0]    nxt;

  // Returns {found, index} of the first word at or after 'from' with a non-zero byte mask.
  function automatic logic [2:0] next_word(input logic [15:0] mask, input logic [2:0] from);
    logic [2:0] r;
    r = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!r[2] && k >= 32'(from) && mask[4*k +: 4] != '0) begin
        r = {1'b1, k[1:0]};
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    rd_pend_d   = rd_pend_q;
    wa_d        = wa_q;
    ra_d        = ra_q;
    wm_d        = wm_q;
    wd_d        = wd_q;
    cidx_d      = cidx_q;
    rcnt_d      = rcnt_q;
    tout_d      = tout_q;
    line_d      = line_q;
    rdat_d      = rdat_q;
    cmd_valid_d = cmd_valid_q;
    cmd_we_d    = cmd_we_q;
    cmd_adr_d   = cmd_adr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_be_d    = cmd_be_q;
    wfin_d      = 1'b0;
    rdone_d     = 1'b0;
    err_d       = err_q;
    start_rd    = 1'b0;
    rd_base     = ra_q;
    nxt         = '0;

    case (state_q)
      IDLE: begin
        if (dcw_start_rq) begin
          wa_d        = dcw_in_addr[31:4];
          wm_d        = dcw_in_mask;
          wd_d        = dcw_in_data;
          nxt         = next_word(dcw_in_mask, 3'd0);
          state_d     = WR_ISSUE;
          cmd_valid_d = nxt[2];
          cmd_we_d    = 1'b1;
          cidx_d      = nxt[1:0];
          cmd_adr_d   = {dcw_in_addr[31:4], nxt[1:0]};
          cmd_be_d    = dcw_in_mask[{nxt[1:0], 2'b00} +: 4];
          cmd_wdata_d = dcw_in_data[{nxt[1:0], 5'b00000} +: 32];
          if (dcr_start_rq) begin
            ra_d      = dcr_rin_addr[31:4];
            rd_pend_d = 1'b1;
          end
        end else if (dcr_start_rq) begin
          ra_d     = dcr_rin_addr[31:4];
          rd_base  = dcr_rin_addr[31:4];
          start_rd = 1'b1;
        end
      end

      WR_ISSUE: begin
        // An all-zero mask enters with no command pending and finishes at once.
        if (!cmd_valid_q) begin
          state_d = WR_DONE;
          wfin_d  = 1'b1;
        end else if (mem_cmd_ready) begin
          nxt = next_word(wm_q, {1'b0, cidx_q} + 3'd1);
          if (nxt[2]) begin
            cidx_d      = nxt[1:0];
            cmd_adr_d   = {wa_q, nxt[1:0]};
            cmd_be_d    = wm_q[{nxt[1:0], 2'b00} +: 4];
            cmd_wdata_d = wd_q[{nxt[1:0], 5'b00000} +: 32];
          end else begin
            cmd_valid_d = 1'b0;
            state_d     = WR_DONE;
            wfin_d      = 1'b1;
          end
        end
      end

      WR_DONE: begin
        if (rd_pend_q) begin
          rd_pend_d = 1'b0;
          start_rd  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      RD_ISSUE, RD_WAIT: begin
        if (state_q == RD_ISSUE && mem_cmd_ready) begin
          if (cidx_q == 2'd3) begin
            cmd_valid_d = 1'b0;
            state_d     = RD_WAIT;
          end else begin
            cidx_d    = cidx_q + 2'd1;
            cmd_adr_d = {ra_q, cidx_q + 2'd1};
          end
        end
        if (mem_rvalid) begin
          line_d[{rcnt_q, 5'b00000} +: 32] = mem_rdata;
          rcnt_d = rcnt_q + 2'd1;
          tout_d = '0;
          if (rcnt_q == 2'd3) begin
            state_d     = RD_DONE;
            rdone_d     = 1'b1;
            rdat_d      = line_d;
            cmd_valid_d = 1'b0;
          end
        end else if (state_q == RD_ISSUE && mem_cmd_ready) begin
          tout_d = '0;
        end else if (tout_q == TOUT_LAST) begin
          err_d       = 1'b1;
          state_d     = RD_DONE;
          rdone_d     = 1'b1;
          cmd_valid_d = 1'b0;
          for (int unsigned k = 0; k < 4; k++) begin
            rdat_d[32*k +: 32] = (k < 32'(rcnt_q)) ? line_q[32*k +: 32] : '0;
          end
        end else begin
          tout_d = tout_q + TOUT_ONE;
        end
      end

      RD_DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    if (start_rd) begin
      state_d     = RD_ISSUE;
      cmd_valid_d = 1'b1;
      cmd_we_d    = 1'b0;
      cmd_be_d    = '0;
      cmd_wdata_d = '0;
      cidx_d      = '0;
      cmd_adr_d   = {rd_base, 2'b00};
      rcnt_d      = '0;
      tout_d      = '0;
      line_d      = '0;
    end

    rqfull_d = (state_d != IDLE) | rd_pend_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_pend_q   <= 1'b0;
      wa_q        <= '0;
      ra_q        <= '0;
      wm_q        <= '0;
      wd_q        <= '0;
      cidx_q      <= '0;
      rcnt_q      <= '0;
      tout_q      <= '0;
      line_q      <= '0;
      rdat_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_adr_q   <= '0;
      cmd_wdata_q <= '0;
      cmd_be_q    <= '0;
      wfin_q      <= 1'b0;
      rdone_q     <= 1'b0;
      rqfull_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= rd_pend_d;
      wa_q        <= wa_d;
      ra_q        <= ra_d;
      wm_q        <= wm_d;
      wd_q        <= wd_d;
      cidx_q      <= cidx_d;
      rcnt_q      <= rcnt_d;
      tout_q      <= tout_d;
      line_q      <= line_d;
      rdat_q      <= rdat_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_we_q    <= cmd_we_d;
      cmd_adr_q   <= cmd_adr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_be_q    <= cmd_be_d;
      wfin_q      <= wfin_d;
      rdone_q     <= rdone_d;
      rqfull_q    <= rqfull_d;
      err_q       <= err_d;
    end
  end

  assign dcw_finish_wresp = wfin_q;
  assign rqfull_1         = rqfull_q;
  assign rdat_m_data      = rdat_q;
  assign rdat_m_valid     = rdone_q;
  assign finish_mrd       = rdone_q;
  assign mem_cmd_valid    = cmd_valid_q;
  assign mem_cmd_we       = cmd_we_q;
  assign mem_cmd_adr      = cmd_adr_q;
  assign mem_cmd_wdata    = cmd_wdata_q;
  assign mem_cmd_be       = cmd_be_q;
  assign bridge_err       = err_q;

endmodule

// File: tb/tb_dc_mem_bridge.sv
// Bench for dc_mem_bridge: behavioural memory with random stalls/latency and a
// line-level reference of expected commands, refill data and completion order.
module tb_dc_mem_bridge;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         dcw_start_rq = 1'b0;
  logic [31:0]  dcw_in_addr = '0;
  logic [15:0]  dcw_in_mask = '0;
  logic [127:0] dcw_in_data = '0;
  logic         dcw_finish_wresp;
  logic         dcr_start_rq = 1'b0;
  logic [31:0]  dcr_rin_addr = '0;
  logic         rqfull_1;
  logic [127:0] rdat_m_data;
  logic         rdat_m_valid;
  logic         finish_mrd;
  logic         mem_cmd_valid;
  logic         mem_cmd_ready = 1'b1;
  logic         mem_cmd_we;
  logic [29:0]  mem_cmd_adr;
  logic [31:0]  mem_cmd_wdata;
  logic [3:0]   mem_cmd_be;
  logic         mem_rvalid = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic         bridge_err;

  dc_mem_bridge #(.TOUT_W(8)) dut (
    .clk(clk), .rst(rst),
    .dcw_start_rq(dcw_start_rq), .dcw_in_addr(dcw_in_addr), .dcw_in_mask(dcw_in_mask),
    .dcw_in_data(dcw_in_data), .dcw_finish_wresp(dcw_finish_wresp),
    .dcr_start_rq(dcr_start_rq), .dcr_rin_addr(dcr_rin_addr), .rqfull_1(rqfull_1),
    .rdat_m_data(rdat_m_data), .rdat_m_valid(rdat_m_valid), .finish_mrd(finish_mrd),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
    .mem_cmd_adr(mem_cmd_adr), .mem_cmd_wdata(mem_cmd_wdata), .mem_cmd_be(mem_cmd_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .bridge_err(bridge_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [29:0] adr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } ret_t;

  cmd_t got[$];
  ret_t rq[$];
  logic [31:0] mem [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];

  int ncmp = 0;
  int nfail = 0;
  int ncyc = 0;
  int lat = 1;
  bit rand_ready = 1'b0;
  int beats_left = 1 << 30;
  bit exp_err = 1'b0;

  function automatic logic [31:0] dflt(input logic [29:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                        input logic [31:0] nw);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Memory: decides ready each cycle, records accepted commands, returns reads in order.
  always @(negedge clk) begin
    ret_t r;
    #1;
    ncyc++;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (rq.size() > 0 && rq[0].due <= ncyc) begin
      r = rq.pop_front();
      if (beats_left > 0) begin
        beats_left--;
        mem_rvalid = 1'b1;
        mem_rdata  = r.data;
      end
    end
    mem_cmd_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (!rst && mem_cmd_valid && mem_cmd_ready) begin
      got.push_back('{mem_cmd_we, mem_cmd_adr, mem_cmd_be, mem_cmd_we ? mem_cmd_wdata : 32'h0});
      if (mem_cmd_we) mem[mem_cmd_adr] = merge(mem_rd(mem_cmd_adr), mem_cmd_be, mem_cmd_wdata);
      else rq.push_back('{ncyc + lat, mem_rd(mem_cmd_adr)});
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request (writeback, refill or both); returns the cycle offsets of the completion pulses.
  task automatic run(input bit dw, input bit dr, input logic [31:0] wa, input logic [15:0] wm,
                     input logic [127:0] wd, input logic [31:0] ra, input int beats,
                     output int t_w, output int t_r);
    cmd_t exp[$];
    logic [127:0] line;
    logic [3:0] be;
    logic [29:0] a;
    int n, nw, nr;
    bit hi_ok, fin_eq;
    line = '0;
    if (dw) begin
      for (int k = 0; k < 4; k++) begin
        be = wm[4*k +: 4];
        a  = {wa[31:4], 2'(k)};
        if (be != 4'h0) begin
          exp.push_back('{1'b1, a, be, wd[32*k +: 32]});
          ref_mem[a] = merge(ref_rd(a), be, wd[32*k +: 32]);
        end
      end
    end
    if (dr) begin
      for (int k = 0; k < 4; k++) begin
        a = {ra[31:4], 2'(k)};
        exp.push_back('{1'b0, a, 4'h0, 32'h0});
        line[32*k +: 32] = (k < beats) ? ref_rd(a) : 32'h0;
      end
    end
    got.delete();
    @(negedge clk);
    dcw_start_rq = dw; dcw_in_addr = wa; dcw_in_mask = wm; dcw_in_data = wd;
    dcr_start_rq = dr; dcr_rin_addr = ra;
    n = 0; nw = 0; nr = 0; t_w = -1; t_r = -1; hi_ok = 1'b1; fin_eq = 1'b1;
    while (n < 2000 && ((dw && nw == 0) || (dr && nr == 0))) begin
      @(negedge clk);
      n++;
      if (n == 1) begin dcw_start_rq = 1'b0; dcr_start_rq = 1'b0; end
      if (rqfull_1 !== 1'b1) hi_ok = 1'b0;
      if (finish_mrd !== rdat_m_valid) fin_eq = 1'b0;
      if (dcw_finish_wresp) begin nw++; if (t_w < 0) t_w = n; end
      if (rdat_m_valid) begin nr++; if (t_r < 0) t_r = n; end
    end
    @(negedge clk);
    check("idle_after", 128'(rqfull_1), 128'(0));
    check("no_extra_pulse", 128'({dcw_finish_wresp, rdat_m_valid, finish_mrd}), 128'(0));
    check("rqfull_held", 128'(hi_ok), 128'(1));
    check("finish_mrd_eq_valid", 128'(fin_eq), 128'(1));
    if (dw) check("wresp_count", 128'(nw), 128'(1));
    if (dr) check("mrd_count", 128'(nr), 128'(1));
    if (dw && dr) check("wr_before_rd", 128'(t_w < t_r), 128'(1));
    check("cmd_count", 128'(got.size()), 128'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) check($sformatf("cmd%0d", i), 128'(got[i]), 128'(exp[i]));
    end
    if (dr) check("rdat_line", rdat_m_data, line);
    check("bridge_err", 128'(bridge_err), 128'(exp_err));
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1);
  end

  initial begin
    int tw, tr, np;
    logic [31:0] a;
    logic [15:0] m;
    logic [127:0] d;
    int kind;

    repeat (3) @(negedge clk);
    check("rst_rqfull", 128'(rqfull_1), 128'(0));
    check("rst_outputs", 128'({mem_cmd_valid, dcw_finish_wresp, rdat_m_valid, finish_mrd, bridge_err}), 128'(0));
    check("rst_rdat", rdat_m_data, 128'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 128'({rqfull_1, mem_cmd_valid}), 128'(0));

    rand_ready = 1'b0; lat = 1;
    run(1, 0, 32'h0000_1230, 16'hFFFF, 128'h44444444_33333333_22222222_11111111, 0, 4, tw, tr);
    check("full_wr_latency", 128'(tw), 128'(5));
    run(1, 0, 32'h0000_5674, 16'h0F00, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 0, 4, tw, tr);
    run(1, 0, 32'h0000_6000, 16'h0000, 128'h1, 0, 4, tw, tr);
    check("zero_mask_latency", 128'(tw), 128'(2));
    run(0, 1, 0, 0, 0, 32'h0000_123C, 4, tw, tr);
    check("min_rd_latency", 128'(tr), 128'(6));

    for (int k = 0; k < 4; k++) begin
      mem[30'h800 + 30'(k)]     = 32'hA0 + 32'(k);
      ref_mem[30'h800 + 30'(k)] = 32'hA0 + 32'(k);
    end
    rand_ready = 1'b1; lat = 3;
    run(0, 1, 0, 0, 0, 32'h0000_2000, 4, tw, tr);
    check("a0_a3_line", rdat_m_data, 128'h000000A3_000000A2_000000A1_000000A0);

    rand_ready = 1'b0; lat = 1;
    run(1, 1, 32'h0000_2000, 16'hFFFF, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 32'h0000_2008, 4, tw, tr);
    check("both_rd_latency", 128'(tr), 128'(11));

    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 2);
      rand_ready = $urandom_range(0, 1);
      lat = $urandom_range(1, 4);
      a = 32'h0000_3000 + ($urandom_range(0, 7) << 4) + $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0: m = 16'h0000;
        1: m = 16'hFFFF;
        default: m = 16'($urandom);
      endcase
      d = {$urandom, $urandom, $urandom, $urandom};
      run(kind != 1, kind != 0, a, m, d,
          32'h0000_3000 + ($urandom_range(0, 7) << 4) + $urandom_range(0, 15), 4, tw, tr);
    end

    rand_ready = 1'b0; lat = 1; beats_left = 2; exp_err = 1'b1;
    run(0, 1, 0, 0, 0, 32'h0000_3010, 2, tw, tr);
    for (int i = 0; i < 50 && rq.size() > 0; i++) @(negedge clk);
    beats_left = 1 << 30;
    rand_ready = 1'b1; lat = 2;
    run(0, 1, 0, 0, 0, 32'h0000_3020, 4, tw, tr);

    rand_ready = 1'b0; lat = 20;
    got.delete();
    @(negedge clk);
    dcr_start_rq = 1'b1; dcr_rin_addr = 32'h0000_4000;
    @(negedge clk);
    dcr_start_rq = 1'b0;
    for (int i = 0; i < 100 && got.size() < 4; i++) @(negedge clk);
    check("rst_test_issued", 128'(got.size()), 128'(4));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err = 1'b0;
    np = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdat_m_valid || finish_mrd || dcw_finish_wresp || mem_cmd_valid) np++;
    end
    check("rst_no_pulses", 128'(np), 128'(0));
    check("rst_rdat_zero", rdat_m_data, 128'(0));
    check("rst_rqfull_low", 128'(rqfull_1), 128'(0));
    check("rst_err_clear", 128'(bridge_err), 128'(0));
    lat = 2;
    run(0, 1, 0, 0, 0, 32'h0000_4000, 4, tw, tr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/dc_mem_bridge.md
# dc_mem_bridge

Data-cache line bridge sitting directly downstream of the CPU core's LSU miss/writeback port. It accepts whole-line (128-bit) writeback and refill requests from the core, splits them into 32-bit single-word beats on a valid/ready memory command port, gathers refill read beats back into a line, and signals completion to the core. One writeback and one refill can be pending at once. Writebacks always complete before a refill is issued.

## Interface
Parameters:
- TOUT_W, 8: width of the refill watchdog counter; timeout fires after 2^TOUT_W-1 idle cycles.

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- dcw_start_rq  in  1  writeback request strobe, 1 cycle
- dcw_in_addr  in  32  line address; [3:0] ignored
- dcw_in_mask  in  16  byte enables; bit b = byte b of line
- dcw_in_data  in  128  line data; word k = [32k+31:32k]
- dcw_finish_wresp  out  1  writeback complete pulse
- dcr_start_rq  in  1  refill request strobe, 1 cycle
- dcr_rin_addr  in  32  refill line address; [3:0] ignored
- rqfull_1  out  1  bridge busy; core must not strobe requests
- rdat_m_data  out  128  refilled line
- rdat_m_valid  out  1  refill data valid pulse
- finish_mrd  out  1  refill complete pulse; same cycle as rdat_m_valid
- mem_cmd_valid  out  1  memory command valid
- mem_cmd_ready  in  1  memory accepts command
- mem_cmd_we  out  1  1 = write, 0 = read
- mem_cmd_adr  out  30  word address [31:2]
- mem_cmd_wdata  out  32  write word
- mem_cmd_be  out  4  write byte enables
- mem_rvalid  in  1  read beat return, in issue order
- mem_rdata  in  32  read beat data
- bridge_err  out  1  sticky: refill timeout occurred; cleared only by rst

## Operation
- States: IDLE, WR_ISSUE, WR_DONE, RD_ISSUE, RD_WAIT, RD_DONE.
- IDLE samples the request strobes:
  - dcw_start_rq: latch addr/mask/data, go to WR_ISSUE.
  - dcr_start_rq alone: latch addr, go to RD_ISSUE.
  - Both strobes in the same cycle: take the write; latch the read into rd_pend.
- WR_ISSUE: walk words 0..3 and skip any word whose 4-bit mask slice is 0.
  - mem_cmd_adr = {addr[31:4], k}, mem_cmd_be = mask[4k+3:4k], we = 1.
  - Advance on valid & ready.
  - After the last non-zero word is accepted, go to WR_DONE. An all-zero mask goes straight to WR_DONE.
- WR_DONE: pulse dcw_finish_wresp for 1 cycle. Next state is RD_ISSUE if rd_pend, else IDLE.
- RD_ISSUE: issue 4 reads, words 0..3, we = 0, be = 0. After the 4th is accepted, go to RD_WAIT.
- Read returns are counted (rcnt, 0..3) from RD_ISSUE onward, so returns may overlap issue. Beat n is stored at word n.
- RD_WAIT: when the 4th beat arrives, go to RD_DONE.
- Watchdog: counts cycles without mem_rvalid while in RD_ISSUE/RD_WAIT; any mem_rvalid resets it. On expiry, set bridge_err, force unfilled words to 0, and go to RD_DONE.
- RD_DONE: pulse rdat_m_valid and finish_mrd, go to IDLE. rdat_m_data holds its value until the next refill writes it.
- rqfull_1 = (state != IDLE) | rd_pend (registered outputs).
- Strobes arriving while rqfull_1 = 1 are ignored. This is a protocol violation with no side effect.
- mem_rvalid outside RD_ISSUE/RD_WAIT is ignored. This covers stale beats after reset.

## Timing
- All outputs reset to 0: rdat_m_data = 0, state = IDLE, rd_pend = 0, counters = 0, bridge_err = 0.
- rst during any state aborts the operation the next cycle. No completion pulse is produced, and the in-flight command is dropped.
- Strobe at cycle T → rqfull_1 = 1 and mem_cmd_valid = 1 from T+1.
- mem_cmd_valid, adr, wdata and be stay stable while ready = 0.
- Minimum write latency, full mask with ready tied high: beats in T+1..T+4, dcw_finish_wresp at T+5, rqfull_1 low at T+6.
- Minimum refill latency, with 1-cycle memory return: commands in T+1..T+4, last beat at T+5, rdat_m_valid/finish_mrd at T+6, rqfull_1 low at T+7.
- Watchdog: with mem_rvalid never asserted, expiry occurs 255 cycles (TOUT_W = 8) after the last beat or command event.

## Test plan
- Full-mask writeback: addr 0x0000_1230, data words 0x11111111..0x44444444, ready = 1 → 4 write commands at adr 0x48C..0x48F with be = 0xF, dcw_finish_wresp 1 cycle after the 4th.
- Sparse mask 0x0F00 → exactly one command: adr word 2, be = 0xF, data word 2. Mask 0x0000 → no commands, finish pulse at T+2.
- Refill of addr 0x0000_2000; memory returns 0xA0..0xA3 with 3-cycle latency and random ready stalls → rdat_m_data = {A3,A2,A1,A0}, single rdat_m_valid/finish_mrd pulse, no command drop or duplication.
- Simultaneous dcw_start_rq and dcr_start_rq → all writes are accepted before the first read command; finish_wresp precedes finish_mrd; rqfull_1 stays high throughout.
- Refill with the memory silent after 2 beats → bridge_err = 1, words 2..3 = 0, finish_mrd pulses; a following refill completes normally with bridge_err still 1.
- rst asserted mid-RD_WAIT, then stale mem_rvalid beats → no pulses, rdat_m_data = 0, rqfull_1 = 0; a subsequent refill returns correct data.
